read_header_sequencer: RTL and testbench

- Read-side controller for the 4-line header register file (2-bit line pointer, 9-bit character pointer packed into an 11-bit read pointer).
- Waits for a committed header line, streams its header bytes out on a byte-wide valid/ready interface, then hands body length and VLAN index to the body engine.
- Waits for that engine's completion, releases the line and advances to the next line.
- Sits between the header RAM/read logic and the egress mux.

---
 rtl/eb_hdr_pkg.sv | 18 +
 rtl/hdr_ptr_counter.sv | 47 ++++
 rtl/read_header_sequencer.sv | 137 +++++++++++++
 tb/tb_read_header_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eb_hdr_pkg.sv
// rtl/eb_hdr_pkg.sv - shared types and widths for the header read sequencer
package eb_hdr_pkg;

    localparam int LINE_W = 2;
    localparam int CHAR_W = 9;
    localparam int PTR_W  = LINE_W + CHAR_W;

    localparam logic [CHAR_W-1:0] HDR_LAST_DEFAULT = 9'd31;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY_REQ,
        WAIT_BODY,
        RELEASE
    } hdr_state_e;

endpackage

// File: rtl/hdr_ptr_counter.sv
// rtl/hdr_ptr_counter.sv - read line / character pointer pair with line wrap
module hdr_ptr_counter
    import eb_hdr_pkg::*;
#(
    parameter int                LINES_LOG2 = LINE_W,
    parameter logic [CHAR_W-1:0] HDR_LAST   = HDR_LAST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  char_inc_i,
    input  logic                  char_clr_i,
    input  logic                  line_adv_i,
    output logic [LINES_LOG2-1:0] rd_line_o,
    output logic [CHAR_W-1:0]     rd_char_o
);

    logic [LINES_LOG2-1:0] line_q, line_d;
    logic [CHAR_W-1:0]     char_q, char_d;

    // Line advance dominates: a freed line always restarts at character 0.
    always_comb begin
        line_d = line_q;
        char_d = char_q;
        if (line_adv_i) begin
            line_d = line_q + LINES_LOG2'(1);
            char_d = '0;
        end else if (char_clr_i) begin
            char_d = '0;
        end else if (char_inc_i && (char_q != HDR_LAST)) begin
            char_d = char_q + CHAR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_q <= '0;
            char_q <= '0;
        end else begin
            line_q <= line_d;
            char_q <= char_d;
        end
    end

    assign rd_line_o = line_q;
    assign rd_char_o = char_q;

endmodule

// File: rtl/read_header_sequencer.sv
// rtl/read_header_sequencer.sv - streams committed header lines, then hands the body to the body engine
module read_header_sequencer
    import eb_hdr_pkg::*;
#(
    parameter logic [CHAR_W-1:0] HDR_LAST   = HDR_LAST_DEFAULT,
    parameter int                LINES_LOG2 = LINE_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [LINES_LOG2-1:0]        wr_line_ptr,
    input  logic                         tlast_flag,
    input  logic [15:0]                  body_length,
    input  logic [3:0]                   vlan_ptr,
    input  logic [7:0]                   rd_data,
    output logic [LINES_LOG2+CHAR_W-1:0] rd_ptr,
    output logic [7:0]                   m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic                         body_req,
    input  logic                         body_ack,
    output logic [15:0]                  body_len,
    output logic [3:0]                   body_vlan,
    input  logic                         body_done,
    output logic                         line_release,
    output logic                         busy
);

    hdr_state_e state_q;

    logic                  m_tvalid_q;
    logic                  body_req_q;
    logic [15:0]           body_len_q;
    logic [3:0]            body_vlan_q;
    logic                  line_release_q;
    logic                  busy_q;

    logic [LINES_LOG2-1:0] rd_line;
    logic [CHAR_W-1:0]     rd_char;
    logic                  handshake;
    logic                  empty;
    logic                  body_zero;

    assign handshake = m_tvalid_q && m_tready;
    assign empty     = (rd_line == wr_line_ptr);
    assign body_zero = (body_length == 16'd0);

    hdr_ptr_counter #(
        .LINES_LOG2 (LINES_LOG2),
        .HDR_LAST   (HDR_LAST)
    ) u_ptr (
        .clk        (clk),
        .rstn       (rstn),
        .char_inc_i ((state_q == HEADER) && handshake && !tlast_flag),
        .char_clr_i (state_q == IDLE),
        .line_adv_i (state_q == RELEASE),
        .rd_line_o  (rd_line),
        .rd_char_o  (rd_char)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            m_tvalid_q     <= 1'b0;
            body_req_q     <= 1'b0;
            body_len_q     <= '0;
            body_vlan_q    <= '0;
            line_release_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q    <= HEADER;
                        m_tvalid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                HEADER: begin
                    if (handshake && tlast_flag) begin
                        m_tvalid_q <= 1'b0;
                        if (!body_zero) begin
                            body_len_q  <= body_length;
                            body_vlan_q <= vlan_ptr;
                            body_req_q  <= 1'b1;
                            state_q     <= BODY_REQ;
                        end else begin
                            line_release_q <= 1'b1;
                            state_q        <= RELEASE;
                        end
                    end
                end
                BODY_REQ: begin
                    // A very short body may finish in the same cycle it is accepted.
                    if (body_ack) begin
                        body_req_q <= 1'b0;
                        if (body_done) begin
                            line_release_q <= 1'b1;
                            state_q        <= RELEASE;
                        end else begin
                            state_q <= WAIT_BODY;
                        end
                    end
                end
                WAIT_BODY: begin
                    if (body_done) begin
                        line_release_q <= 1'b1;
                        state_q        <= RELEASE;
                    end
                end
                RELEASE: begin
                    line_release_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q        <= IDLE;
                    m_tvalid_q     <= 1'b0;
                    body_req_q     <= 1'b0;
                    line_release_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ptr       = {rd_line, rd_char};
    assign m_tdata      = rd_data;
    assign m_tvalid     = m_tvalid_q;
    assign m_tlast      = tlast_flag && body_zero && m_tvalid_q;
    assign body_req     = body_req_q;
    assign body_len     = body_len_q;
    assign body_vlan    = body_vlan_q;
    assign line_release = line_release_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_read_header_sequencer.sv
// tb/tb_read_header_sequencer.sv - directed scoreboard bench for read_header_sequencer
module tb_read_header_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  wr_line_ptr;
    logic        tlast_flag;
    logic [15:0] body_length;
    logic [3:0]  vlan_ptr;
    logic [7:0]  rd_data;
    logic [10:0] rd_ptr;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        body_req;
    logic        body_ack;
    logic [15:0] body_len;
    logic [3:0]  body_vlan;
    logic        body_done;
    logic        line_release;
    logic        busy;

    logic [15:0] blen [4];
    logic [3:0]  vtab [4];
    logic        bp_mode;

    typedef struct packed {
        logic [10:0] ptr;
        logic [7:0]  data;
        logic        last;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int hs_cnt, rel_cnt, req_rise, stall_cnt, cyc, last_hs_cyc, rel_cyc;
    logic        prev_stall, prev_req;
    logic [10:0] prev_ptr;
    logic [7:0]  prev_data;

    always #5 clk = ~clk;

    read_header_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_line_ptr  (wr_line_ptr),
        .tlast_flag   (tlast_flag),
        .body_length  (body_length),
        .vlan_ptr     (vlan_ptr),
        .rd_data      (rd_data),
        .rd_ptr       (rd_ptr),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .body_req     (body_req),
        .body_ack     (body_ack),
        .body_len     (body_len),
        .body_vlan    (body_vlan),
        .body_done    (body_done),
        .line_release (line_release),
        .busy         (busy)
    );

    function automatic logic [7:0] ram_byte(input logic [10:0] p);
        return 8'(p * 7) ^ 8'h5A;
    endfunction

    // Header RAM and read-logic model: asynchronous reads at rd_ptr.
    always_comb begin
        rd_data     = ram_byte(rd_ptr);
        tlast_flag  = (rd_ptr[8:0] == 9'd31);
        body_length = blen[rd_ptr[10:9]];
        vlan_ptr    = vtab[rd_ptr[10:9]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [1:0] line);
        for (int c = 0; c < 32; c++) begin
            exp_t e;
            e.ptr  = {line, 9'(c)};
            e.data = ram_byte(e.ptr);
            e.last = (c == 31) && (blen[line] == 16'd0);
            sb.push_back(e);
        end
    endtask

    task automatic clear_counts();
        hs_cnt    = 0;
        rel_cnt   = 0;
        req_rise  = 0;
        stall_cnt = 0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        @(negedge clk);
        while (body_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("body_req_seen", 32'(body_req), 1);
    endtask

    task automatic wait_release(input int budget);
        int n = 0;
        @(negedge clk);
        while (line_release !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("line_release_seen", 32'(line_release), 1);
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) m_tready = ~m_tready;
            else         m_tready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_tvalid), 1);
                check("stall_ptr", 32'(rd_ptr), 32'(prev_ptr));
                check("stall_data", 32'(m_tdata), 32'(prev_data));
            end
            if (m_tvalid && m_tready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("byte_ptr", 32'(rd_ptr), 32'(e.ptr));
                    check("byte_data", 32'(m_tdata), 32'(e.data));
                    check("byte_last", 32'(m_tlast), 32'(e.last));
                end
                hs_cnt++;
                if (m_tlast) last_hs_cyc = cyc;
            end
            if (line_release) begin
                rel_cnt++;
                rel_cyc = cyc;
            end
            if (body_req && !prev_req) req_rise++;
            prev_stall = m_tvalid && !m_tready;
            if (prev_stall) stall_cnt++;
            prev_ptr  = rd_ptr;
            prev_data = m_tdata;
            prev_req  = body_req;
        end else begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end
    end

    initial begin
        rstn        = 1'b0;
        wr_line_ptr = 2'd0;
        body_ack    = 1'b0;
        body_done   = 1'b0;
        bp_mode     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            blen[i] = 16'd0;
            vtab[i] = 4'd0;
        end
        step(3);
        check("rst_rd_ptr", 32'(rd_ptr), 0);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_body_req", 32'(body_req), 0);
        check("rst_body_len", 32'(body_len), 0);
        check("rst_body_vlan", 32'(body_vlan), 0);
        check("rst_line_release", 32'(line_release), 0);
        check("rst_busy", 32'(busy), 0);
        rstn = 1'b1;
        step(2);
        check("empty_idle_busy", 32'(busy), 0);

        // Frame with body on line 0
        blen[0] = 16'd100;
        vtab[0] = 4'd5;
        clear_counts();
        push_frame(2'd0);
        wr_line_ptr = 2'd1;
        @(negedge clk);
        check("latency_idle", 32'(m_tvalid), 0);
        @(negedge clk);
        check("latency_first", 32'(m_tvalid), 1);
        wait_req(100);
        check("f1_sb_drained", 32'(sb.size()), 0);
        check("f1_bytes", 32'(hs_cnt), 32);
        check("f1_body_len", 32'(body_len), 100);
        check("f1_body_vlan", 32'(body_vlan), 5);
        check("f1_busy", 32'(busy), 1);
        check("f1_tvalid_off", 32'(m_tvalid), 0);
        step(1);
        body_ack = 1'b1;
        step(1);
        body_ack = 1'b0;
        @(negedge clk);
        check("f1_req_dropped", 32'(body_req), 0);
        step(9);
        check("f1_wait_hold", 32'(rel_cnt), 0);
        body_done = 1'b1;
        step(1);
        body_done = 1'b0;
        wait_release(10);
        step(1);
        check("f1_rd_ptr", 32'(rd_ptr), 32'h200);
        check("f1_busy_idle", 32'(busy), 0);
        check("f1_releases", 32'(rel_cnt), 1);
        body_done = 1'b1;
        step(1);
        body_done = 1'b0;
        @(negedge clk);
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_release", 32'(line_release), 0);

        // Zero-length body on line 1
        blen[1] = 16'd0;
        vtab[1] = 4'd3;
        clear_counts();
        push_frame(2'd1);
        wr_line_ptr = 2'd2;
        wait_release(100);
        step(1);
        check("f2_sb_drained", 32'(sb.size()), 0);
        check("f2_bytes", 32'(hs_cnt), 32);
        check("f2_no_req", 32'(req_rise), 0);
        check("f2_release_next", 32'(rel_cyc), 32'(last_hs_cyc + 1));
        check("f2_rd_ptr", 32'(rd_ptr), 32'h400);
        check("f2_releases", 32'(rel_cnt), 1);

        // Backpressure on line 2
        blen[2] = 16'd7;
        vtab[2] = 4'd9;
        clear_counts();
        bp_mode = 1'b1;
        push_frame(2'd2);
        wr_line_ptr = 2'd3;
        wait_req(200);
        bp_mode = 1'b0;
        check("f3_sb_drained", 32'(sb.size()), 0);
        check("f3_bytes", 32'(hs_cnt), 32);
        check("f3_stalls_seen", 32'(stall_cnt != 0), 1);
        check("f3_body_len", 32'(body_len), 7);
        check("f3_body_vlan", 32'(body_vlan), 9);
        step(1);
        body_ack = 1'b1;
        step(1);
        body_ack = 1'b0;
        step(2);
        body_done = 1'b1;
        step(1);
        body_done = 1'b0;
        wait_release(10);
        step(1);
        check("f3_rd_ptr", 32'(rd_ptr), 32'h600);
        check("f3_releases", 32'(rel_cnt), 1);

        // Line 3 with ack and done in the same cycle; pointer wraps to line 0
        blen[3] = 16'd40;
        vtab[3] = 4'd12;
        clear_counts();
        push_frame(2'd3);
        wr_line_ptr = 2'd0;
        wait_req(100);
        check("f4_body_len", 32'(body_len), 40);
        check("f4_body_vlan", 32'(body_vlan), 12);
        step(1);
        body_ack  = 1'b1;
        body_done = 1'b1;
        step(1);
        body_ack  = 1'b0;
        body_done = 1'b0;
        @(negedge clk);
        check("f4_direct_release", 32'(line_release), 1);
        check("f4_req_dropped", 32'(body_req), 0);
        step(1);
        check("f4_rd_ptr_wrap", 32'(rd_ptr), 0);
        step(5);
        check("f4_idle_busy", 32'(busy), 0);
        check("f4_idle_tvalid", 32'(m_tvalid), 0);
        check("f4_releases", 32'(rel_cnt), 1);

        // Asynchronous reset mid-frame on line 0
        blen[0] = 16'd0;
        vtab[0] = 4'd2;
        clear_counts();
        push_frame(2'd0);
        wr_line_ptr = 2'd1;
        begin
            int n = 0;
            while (hs_cnt < 17 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("f5_reached_byte17", 32'(hs_cnt >= 17), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_rd_ptr", 32'(rd_ptr), 0);
        check("mid_rst_m_tvalid", 32'(m_tvalid), 0);
        check("mid_rst_m_tlast", 32'(m_tlast), 0);
        check("mid_rst_body_req", 32'(body_req), 0);
        check("mid_rst_body_len", 32'(body_len), 0);
        check("mid_rst_body_vlan", 32'(body_vlan), 0);
        check("mid_rst_line_release", 32'(line_release), 0);
        check("mid_rst_busy", 32'(busy), 0);
        sb.delete();
        wr_line_ptr = 2'd0;
        step(2);
        rstn = 1'b1;
        step(1);
        clear_counts();
        push_frame(2'd0);
        wr_line_ptr = 2'd1;
        wait_release(100);
        step(1);
        check("f6_sb_drained", 32'(sb.size()), 0);
        check("f6_bytes", 32'(hs_cnt), 32);
        check("f6_rd_ptr", 32'(rd_ptr), 32'h200);
        check("f6_releases", 32'(rel_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
